// File: rtl/reg_file_pkg.sv
// Shared constants and types for the multi-port integer register file.
package reg_file_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 32;
  localparam int AW_DEF    = $clog2(DEPTH_DEF);
  localparam int REG_ZERO  = 0;

  typedef logic [AW_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/reg_file_mp_if.sv
// Issue/writeback-side bundle of the register file: write ports, read ports, busy-set port.
interface reg_file_mp_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int NR    = 2,
  parameter int NW    = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [NW-1:0]           wr_en;
  logic [NW-1:0][AW-1:0]   wr_addr;
  logic [NW-1:0][XLEN-1:0] wr_data;
  logic [NR-1:0][AW-1:0]   rd_addr;
  logic [NR-1:0][XLEN-1:0] rd_data;
  logic [NR-1:0]           rd_busy;
  logic                    busy_set_en;
  logic [AW-1:0]           busy_set_addr;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, busy_set_en, busy_set_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, busy_set_en, busy_set_addr,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: one set port, NW clear ports, NR combinational lookups.
// A set beats a same-cycle clear; with bypass, a same-cycle clear hides the busy bit.
module reg_scoreboard #(
  parameter int DEPTH  = 32,
  parameter int NR     = 2,
  parameter int NW     = 2,
  parameter bit BYPASS = 1'b1,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  set_en_i,
  input  logic [AW-1:0]         set_addr_i,
  input  logic [NW-1:0]         clr_en_i,
  input  logic [NW-1:0][AW-1:0] clr_addr_i,
  input  logic [NR-1:0][AW-1:0] lk_addr_i,
  output logic [NR-1:0]         lk_busy_o
);
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NW; i++) begin
      if (clr_en_i[i]) busy_d[clr_addr_i[i]] = 1'b0;
    end
    // Applied after the clears: a newly issued producer outranks the retiring one.
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    lk_busy_o = '0;
    for (int j = 0; j < NR; j++) begin
      lk_busy_o[j] = busy_q[lk_addr_i[j]];
      if (BYPASS) begin
        for (int i = 0; i < NW; i++) begin
          if (clr_en_i[i] && (clr_addr_i[i] == lk_addr_i[j])) lk_busy_o[j] = 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with optional write-to-read bypass and busy-bit scoreboard.
// Highest-index write port wins on address collisions, for storage and bypass alike.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  reg_file_mp_if.slave rf
);
  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0]         mem_q [DEPTH];
  logic [XLEN-1:0]         mem_d [DEPTH];
  logic [NW-1:0]           wr_ok;
  logic                    set_ok;
  logic [NR-1:0]           byp_hit;
  logic [NR-1:0][XLEN-1:0] byp_dat;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return ZERO_REG && (a == AW'(REG_ZERO));
  endfunction

  // Hardwired-zero register: its writes and busy sets are dropped here, before storage and scoreboard.
  always_comb begin
    wr_ok = '0;
    for (int i = 0; i < NW; i++) wr_ok[i] = rf.wr_en[i] && !is_zero(rf.wr_addr[i]);
    set_ok = rf.busy_set_en && !is_zero(rf.busy_set_addr);
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NW; i++) begin
      if (wr_ok[i]) mem_d[rf.wr_addr[i]] = rf.wr_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  if (BYPASS) begin : g_byp
    always_comb begin
      byp_hit = '0;
      byp_dat = '0;
      for (int j = 0; j < NR; j++) begin
        for (int i = 0; i < NW; i++) begin
          if (wr_ok[i] && (rf.wr_addr[i] == rf.rd_addr[j])) begin
            byp_hit[j] = 1'b1;
            byp_dat[j] = rf.wr_data[i];
          end
        end
      end
    end
  end else begin : g_nobyp
    assign byp_hit = '0;
    assign byp_dat = '0;
  end

  always_comb begin
    rf.rd_data = '0;
    for (int j = 0; j < NR; j++) begin
      rf.rd_data[j] = byp_hit[j] ? byp_dat[j] : mem_q[rf.rd_addr[j]];
      if (is_zero(rf.rd_addr[j])) rf.rd_data[j] = '0;
    end
  end

  reg_scoreboard #(
    .DEPTH  (DEPTH),
    .NR     (NR),
    .NW     (NW),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_sb (
    .clk        (clk),
    .rstn       (rstn),
    .set_en_i   (set_ok),
    .set_addr_i (rf.busy_set_addr),
    .clr_en_i   (wr_ok),
    .clr_addr_i (rf.wr_addr),
    .lk_addr_i  (rf.rd_addr),
    .lk_busy_o  (rf.rd_busy)
  );
endmodule

// File: tb/tb_reg_file_mp.sv
// Two configurations side by side (bypass+zero-reg, and neither) driven with identical stimulus.
module tb_reg_file_mp;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic [1:0][4:0]  rd_addr;
  logic             set_en;
  logic [4:0]       set_addr;

  int vectors = 0;
  int miscompares = 0;

  // Architectural state per configuration: index 0 = dut_a, index 1 = dut_b.
  logic [31:0] m_reg  [2][32];
  bit          m_busy [2][32];

  reg_file_mp_if #(.XLEN(32), .DEPTH(32), .NR(2), .NW(2)) if_a ();
  reg_file_mp_if #(.XLEN(32), .DEPTH(32), .NR(2), .NW(2)) if_b ();

  assign if_a.wr_en = wr_en;       assign if_b.wr_en = wr_en;
  assign if_a.wr_addr = wr_addr;   assign if_b.wr_addr = wr_addr;
  assign if_a.wr_data = wr_data;   assign if_b.wr_data = wr_data;
  assign if_a.rd_addr = rd_addr;   assign if_b.rd_addr = rd_addr;
  assign if_a.busy_set_en = set_en;     assign if_b.busy_set_en = set_en;
  assign if_a.busy_set_addr = set_addr; assign if_b.busy_set_addr = set_addr;

  reg_file_mp #(.XLEN(32), .DEPTH(32), .NR(2), .NW(2), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_a (
    .clk (clk), .rstn (rstn), .rf (if_a.slave)
  );
  reg_file_mp #(.XLEN(32), .DEPTH(32), .NR(2), .NW(2), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_b (
    .clk (clk), .rstn (rstn), .rf (if_b.slave)
  );

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; set_en = 1'b0; set_addr = '0;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < 2; c++) begin
      for (int j = 0; j < 2; j++) begin
        bit          byp = (c == 0);
        bit          zr  = (c == 0);
        logic [4:0]  a   = rd_addr[j];
        logic [31:0] ed, gd;
        logic        eb, gb;
        if (zr && a == 5'd0) begin
          ed = '0; eb = 1'b0;
        end else begin
          ed = m_reg[c][a]; eb = m_busy[c][a];
          if (byp) begin
            for (int i = 0; i < 2; i++) begin
              if (wr_en[i] && wr_addr[i] == a) begin ed = wr_data[i]; eb = 1'b0; end
            end
          end
        end
        gd = (c == 0) ? if_a.rd_data[j] : if_b.rd_data[j];
        gb = (c == 0) ? if_a.rd_busy[j] : if_b.rd_busy[j];
        vectors += 2;
        if (gd !== ed) begin
          miscompares++;
          $display("FAIL rd_data cfg%0d port%0d addr%0d t=%0t: got %h want %h", c, j, a, $time, gd, ed);
        end
        if (gb !== eb) begin
          miscompares++;
          $display("FAIL rd_busy cfg%0d port%0d addr%0d t=%0t: got %b want %b", c, j, a, $time, gb, eb);
        end
      end
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      bit zr = (c == 0);
      if (!rstn) begin
        for (int k = 0; k < 32; k++) begin m_reg[c][k] = '0; m_busy[c][k] = 1'b0; end
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (wr_en[i] && !(zr && wr_addr[i] == 5'd0)) begin
            m_reg[c][wr_addr[i]] = wr_data[i];
            m_busy[c][wr_addr[i]] = 1'b0;
          end
        end
        if (set_en && !(zr && set_addr == 5'd0)) m_busy[c][set_addr] = 1'b1;
      end
    end
  endtask

  // Caller has set inputs and waited #1 after the falling edge.
  task automatic cycle();
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 32; k++) begin m_reg[c][k] = 'x; m_busy[c][k] = 1'b0; end
    idle(); rd_addr = '0; rstn = 1'b0;
    @(negedge clk); #1;
    @(posedge clk); model_edge(); @(negedge clk);
    rstn = 1'b1; #1; cycle();

    // Reset clears data and busy
    wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF; set_en = 1'b1; set_addr = 5'd5;
    #1; cycle();
    idle(); rd_addr[0] = 5'd5; #1;
    lit("pre_reset_data_a", if_a.rd_data[0], 32'hDEADBEEF);
    lit("pre_reset_busy_b", {31'b0, if_b.rd_busy[0]}, 32'd1);
    cycle();
    rstn = 1'b0; #1; cycle();
    rstn = 1'b1; #1;
    lit("reset_data_a", if_a.rd_data[0], 32'h0);
    lit("reset_data_b", if_b.rd_data[0], 32'h0);
    lit("reset_busy_a", {31'b0, if_a.rd_busy[0]}, 32'd0);
    cycle();

    // Write collision: port 1 wins
    wr_en = 2'b11; wr_addr[0] = 5'd3; wr_addr[1] = 5'd3; wr_data[0] = 32'h11; wr_data[1] = 32'h22;
    rd_addr[0] = 5'd3; #1;
    lit("collision_bypass_a", if_a.rd_data[0], 32'h22);
    lit("collision_old_b", if_b.rd_data[0], 32'h0);
    cycle();
    idle(); #1;
    lit("collision_stored_b", if_b.rd_data[0], 32'h22);
    cycle();

    // Bypass versus next-cycle visibility
    wr_en = 2'b10; wr_addr[1] = 5'd7; wr_data[1] = 32'hCAFE; rd_addr[1] = 5'd7; #1;
    lit("bypass_a", if_a.rd_data[1], 32'hCAFE);
    lit("nobypass_old_b", if_b.rd_data[1], 32'h0);
    cycle();
    idle(); #1;
    lit("nobypass_next_b", if_b.rd_data[1], 32'hCAFE);
    cycle();

    // Scoreboard set then clear by write
    set_en = 1'b1; set_addr = 5'd9; rd_addr[0] = 5'd9; #1; cycle();
    idle(); #1;
    lit("busy9_a", {31'b0, if_a.rd_busy[0]}, 32'd1);
    cycle();
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h99; #1;
    lit("busy9_bypass_clear_a", {31'b0, if_a.rd_busy[0]}, 32'd0);
    lit("busy9_still_b", {31'b0, if_b.rd_busy[0]}, 32'd1);
    cycle();
    idle(); #1;
    lit("busy9_cleared_b", {31'b0, if_b.rd_busy[0]}, 32'd0);
    cycle();

    // Set and clear on the same register: set wins
    set_en = 1'b1; set_addr = 5'd4; wr_en = 2'b10; wr_addr[1] = 5'd4; wr_data[1] = 32'h44;
    rd_addr[0] = 5'd4; #1; cycle();
    idle(); #1;
    lit("setwins_a", {31'b0, if_a.rd_busy[0]}, 32'd1);
    lit("setwins_b", {31'b0, if_b.rd_busy[0]}, 32'd1);
    cycle();
    wr_en = 2'b01; wr_addr[0] = 5'd4; wr_data[0] = 32'h45; #1; cycle();
    idle(); #1;
    lit("later_clear_b", {31'b0, if_b.rd_busy[0]}, 32'd0);
    cycle();

    // Register zero
    wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFF_FFFF; set_en = 1'b1; set_addr = 5'd0;
    rd_addr[0] = 5'd0; rd_addr[1] = 5'd0; #1;
    lit("zero_bypass_a0", if_a.rd_data[0], 32'h0);
    lit("zero_bypass_a1", if_a.rd_data[1], 32'h0);
    cycle();
    idle(); #1;
    lit("zero_data_a", if_a.rd_data[1], 32'h0);
    lit("zero_busy_a", {31'b0, if_a.rd_busy[0]}, 32'd0);
    lit("ordinary_r0_data_b", if_b.rd_data[0], 32'hFFFF_FFFF);
    lit("ordinary_r0_busy_b", {31'b0, if_b.rd_busy[1]}, 32'd1);
    cycle();

    // Randomized traffic, concentrated on a few registers to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      bit narrow = ($urandom_range(0, 1) == 1);
      rstn = ($urandom_range(0, 99) != 0);
      wr_en = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        wr_addr[i] = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
        wr_data[i] = $urandom;
        rd_addr[i] = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      end
      set_en = ($urandom_range(0, 2) == 0);
      set_addr = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      #1; cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
